// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Segment patterns are ordered {a,b,c,d,e,f,g}; 1 = lit.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ERR   = 7'b1001111;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    function automatic logic is_bcd(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Datapath-to-display bundle: BCD load/blank controls in, segment/anode pins out.
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   bcd_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic                    blank;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    err;

    modport master (output load, bcd_in, dp_in, blank, input seg, dp, an, err);
    modport slave  (input load, bcd_in, dp_in, blank, output seg, dp, an, err);
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational BCD-to-7-segment decoder; codes 10..15 show "E" and drop valid.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg,
    output logic       valid
);

    // Table lookup for legal codes, error glyph otherwise
    always_comb begin
        valid = is_bcd(code);
        if (valid) begin
            seg = SEG_TABLE[code];
        end else begin
            seg = SEG_ERR;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: latches a packed BCD word and scans
// a one-hot anode across the digits with leading-zero blanking and an error flag.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [PRE_W-1:0]        pre_cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*N_DIGITS-1:0]   digits_r;
    logic [N_DIGITS-1:0]     dp_req_r;
    logic [N_DIGITS-1:0]     an_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic                    err_r;

    logic [6:0]              dig_seg_s [N_DIGITS];
    logic [N_DIGITS-1:0]     valid_s;
    logic [N_DIGITS-1:0]     suppress_s;
    logic [N_DIGITS-1:0]     an_s;
    logic [6:0]              act_seg_s;
    logic                    act_dp_s;
    logic                    zero_run_s;

    // Every latched digit is decoded in parallel; the valid flags feed err
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        seg7_digit_decode u_dec (
            .code  (digits_r[4*g +: 4]),
            .seg   (dig_seg_s[g]),
            .valid (valid_s[g])
        );
    end

    // Prescaler and digit index; idx moves only on prescaler wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= '0;
            idx_r     <= '0;
        end else if (pre_cnt_r == PRE_LAST) begin
            pre_cnt_r <= '0;
            idx_r     <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
        end else begin
            pre_cnt_r <= pre_cnt_r + 1'b1;
        end
    end

    // Capture the BCD word and decimal-point requests on load
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r <= '0;
            dp_req_r <= '0;
        end else if (bus.load) begin
            digits_r <= bus.bcd_in;
            dp_req_r <= bus.dp_in;
        end else begin
            digits_r <= digits_r;
            dp_req_r <= dp_req_r;
        end
    end

    // Leading-zero mask (scanned from the top digit down) and active-digit select
    always_comb begin
        an_s       = '0;
        act_seg_s  = SEG_BLANK;
        act_dp_s   = 1'b0;
        suppress_s = '0;
        zero_run_s = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run_s    = zero_run_s && (digits_r[4*k +: 4] == 4'd0);
            suppress_s[k] = (LZ_SUPPRESS != 0) && (k != 0) && zero_run_s;
        end
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                an_s[k]   = 1'b1;
                act_seg_s = suppress_s[k] ? SEG_BLANK : dig_seg_s[k];
                act_dp_s  = dp_req_r[k];
            end else begin
                an_s[k]   = 1'b0;
            end
        end
    end

    // Output registers; blank gates the pins but never the error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= '0;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b0;
            err_r <= 1'b0;
        end else begin
            err_r <= ~&valid_s;
            if (bus.blank) begin
                an_r  <= '0;
                seg_r <= SEG_BLANK;
                dp_r  <= 1'b0;
            end else begin
                an_r  <= an_s;
                seg_r <= act_seg_s;
                dp_r  <= act_dp_s;
            end
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;
    assign bus.err = err_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: directed scenarios plus random load/blank/reset traffic,
// compared cycle by cycle against an arithmetic model of the display.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

    seg7_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(RD), .LZ_SUPPRESS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_val;
    int          m_dp;
    int          m_ticks;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b1001111;
        endcase
    endfunction

    function automatic int cur_digit();
        return (m_ticks / RD) % N;
    endfunction

    // One clock: predict the post-edge outputs from the model, compare, advance model.
    task automatic cycle();
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        logic       e_err;
        int         idx;
        idx   = cur_digit();
        e_err = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (((m_val >> (4*k)) & 15) > 9) e_err = 1'b1;
        end
        e_seg = 7'b0;
        e_an  = 4'b0;
        e_dp  = 1'b0;
        if (rst) begin
            e_err = 1'b0;
        end else if (!bus.blank) begin
            e_seg = (idx != 0 && (m_val >> (4*idx)) == 0) ? 7'b0 : glyph((m_val >> (4*idx)) & 15);
            e_an  = 4'(1 << idx);
            e_dp  = ((m_dp >> idx) & 1) != 0;
        end
        @(posedge clk);
        #1;
        check("an",  16'(bus.an),  16'(e_an));
        check("seg", 16'(bus.seg), 16'(e_seg));
        check("dp",  16'(bus.dp),  16'(e_dp));
        check("err", 16'(bus.err), 16'(e_err));
        if (rst) begin
            m_val   = 0;
            m_dp    = 0;
            m_ticks = 0;
        end else begin
            if (bus.load) begin
                m_val = int'(bus.bcd_in);
                m_dp  = int'(bus.dp_in);
            end
            m_ticks++;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.load   = 1'b1;
        bus.bcd_in = v;
        bus.dp_in  = d;
        cycle();
        bus.load   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        bus.blank  = 1'b0;
        m_val = 0; m_dp = 0; m_ticks = 0;
        run(3);
        rst = 1'b0;

        // Idle after reset: digit 0 shows "0", upper digits suppressed
        cycle();
        check("first_an",  16'(bus.an),  16'h0001);
        check("first_seg", 16'(bus.seg), 16'(7'b1111110));
        run(2 * N * RD);

        do_load(16'h1905, 4'b0010);
        run(N * RD + 3);

        do_load(16'h00A3, 4'b0000);
        check("err_set", 16'(bus.err), 16'h0000);
        cycle();
        check("err_after", 16'(bus.err), 16'h0001);
        run(N * RD);
        do_load(16'h0003, 4'b0000);
        cycle();
        check("err_clear", 16'(bus.err), 16'h0000);

        // Load while digit 1 is mid-dwell
        guard = 0;
        while (!(cur_digit() == 1 && (m_ticks % RD) == 1) && guard < 64) begin
            cycle();
            guard++;
        end
        check("mid_dwell_reach", 16'(guard < 64), 16'h0001);
        do_load(16'h0042, 4'b0000);
        check("mid_an", 16'(bus.an), 16'h0002);
        cycle();
        check("mid_seg", 16'(bus.seg), 16'(7'b0110011));
        run(N * RD);

        bus.blank = 1'b1;
        run(10);
        bus.blank = 1'b0;
        run(N * RD);

        // Reset with a coincident load during digit 2
        guard = 0;
        while (cur_digit() != 2 && guard < 64) begin
            cycle();
            guard++;
        end
        check("rst_reach", 16'(guard < 64), 16'h0001);
        rst        = 1'b1;
        bus.load   = 1'b1;
        bus.bcd_in = 16'h9876;
        cycle();
        check("rst_digits", dut.digits_r, 16'h0000);
        rst      = 1'b0;
        bus.load = 1'b0;
        cycle();
        check("rst_an",  16'(bus.an),  16'h0001);
        check("rst_seg", 16'(bus.seg), 16'(7'b1111110));

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h0FFF;
                1: v = v & 16'h00FF;
                2: v = v & 16'h000F;
                default: v = v;
            endcase
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (v[4*k +: 4] > 4'd9) v[4*k +: 4] = v[4*k +: 4] - 4'd6;
                end
            end
            bus.load   = ($urandom_range(0, 9) == 0);
            bus.bcd_in = v;
            bus.dp_in  = 4'($urandom);
            if ($urandom_range(0, 39) == 0) bus.blank = ~bus.blank;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst       = 1'b0;
        bus.load  = 1'b0;
        bus.blank = 1'b0;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed N-digit 7-segment display driver. It latches a packed BCD word and walks a one-hot digit enable across N digits at a programmable refresh rate, driving the decoded segment pattern for the active digit. Leading zeros can be suppressed, and invalid BCD codes are flagged. It sits between the datapath's BCD result registers and the board-level segment/anode pins.

## Interface
- `N_DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 1000: clock cycles each digit stays active; legal range ≥ 1.
- `LZ_SUPPRESS`, 1: 1 blanks leading zeros; 0 shows every digit.
- `clk` in 1: single clock; every register is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: single-cycle strobe that captures `bcd_in` and `dp_in`.
- `bcd_in` in 4*N_DIGITS: packed BCD value; digit k is bits [4k+3:4k]; digit 0 is least significant.
- `dp_in` in N_DIGITS: decimal-point request per digit.
- `blank` in 1: level input; 1 turns the whole display off.
- `seg` out 7: segments {a,b,c,d,e,f,g}, a is the MSB, 1 = lit.
- `dp` out 1: decimal point for the active digit, 1 = lit.
- `an` out N_DIGITS: one-hot digit enable, 1 = active.
- `err` out 1: high while any latched digit holds a code of 10..15.

## Operation
- **Latch**
  - On a cycle with `load`=1, `bcd_in` goes to `digits_q` and `dp_in` goes to `dp_q`.
  - Without `load`, the latched values hold indefinitely.
- **Prescaler**
  - `pre_cnt` counts 0..REFRESH_DIV-1 and wraps to 0.
  - On the wrap cycle, `idx` advances by 1, wrapping N_DIGITS-1 → 0.
  - `idx` advances only on prescaler wrap, never otherwise.
- **Digit decode** (pure combinational function of one 4-bit code):
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
  - 10..15: 1001111 ("E"), and the digit is marked invalid.
- **Leading-zero suppression** (LZ_SUPPRESS=1):
  - Digit k is suppressed if it and every digit above it are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit drives `seg`=0 but still drives its `dp` request; `an` still scans it.
- **Error flag**
  - `err` = OR of the invalid flags over all latched digits.
  - It is registered and updates the cycle after `load`.
- **Blanking**
  - `blank`=1 forces `an`=0, `seg`=0 and `dp`=0.
  - Counters keep running under blank.
  - `err` is unaffected by blank.
- **No FSM beyond the scan counters.** State is `pre_cnt` (`$clog2(REFRESH_DIV)` bits, minimum 1), `idx` (`$clog2(N_DIGITS)` bits, minimum 1), `digits_q`, `dp_q`, and the output registers.

## Timing
- **Reset values:**
  - `digits_q`=0, `dp_q`=0, `pre_cnt`=0, `idx`=0.
  - `an`=0, `seg`=0, `dp`=0, `err`=0.
- **Outputs are registered:** `an`/`seg`/`dp` reflect `idx` and the latched data with one cycle of latency.
  - First cycle after reset release: `an`=…0001 and `seg` shows digit 0 of `digits_q`.
  - With `digits_q`=0, that is "0", i.e. 1111110.
- **Digit dwell:** each digit is active for exactly REFRESH_DIV cycles. A full frame is N_DIGITS×REFRESH_DIV cycles.
- **REFRESH_DIV=1:** `idx` advances every cycle.
- **N_DIGITS=1:** `an` is constantly 1 outside blank and reset.
- **Load mid-scan:**
  - New data appears on `seg` one cycle after the load edge, for whatever digit is active.
  - Scan position and `pre_cnt` are not disturbed.
- **Simultaneous events:**
  - `load` and `rst` in the same cycle: reset wins, nothing is latched.
  - `load` and `blank` together: data is latched, outputs stay off.
- **Reset mid-frame:** all outputs return to reset values on the next edge, and scan restarts at digit 0.
- **No `load` handshake:** `load` is always accepted, with no backpressure.

## Structure
- **Package `seg7_pkg`:**
  - Localparams `SEG_BLANK`=0000000 and `SEG_ERR`=1001111.
  - A 10-entry constant array of digit patterns.
  - Function `is_bcd(code)`.
- **Sub-module `seg7_digit_decode`:** combinational; 4-bit in; 7-bit `seg` and 1-bit `valid` out.
  - The top instantiates N_DIGITS copies for the error OR.
  - The top muxes the active digit through one copy for the `seg` path.
- **Top level:** prescaler, index counter, latch, suppression mask generation and output registers. Target size is 150–250 lines.

## Test plan
Bench parameters: N_DIGITS=4, REFRESH_DIV=4, LZ_SUPPRESS=1.

- **Reset, then idle:**
  - `an` sequence 0001, 0010, 0100, 1000, each held 4 cycles, then repeats.
  - `seg`=1111110 only while `an`=0001; 0 elsewhere (suppressed).
- **Load 0x1905, `dp_in`=0010:**
  - `seg` per digit 0..3 = 1011011, 1111110, 1111011, 0110000.
  - `dp`=1 only while `an`=0010.
  - `err`=0.
- **Load 0x00A3:**
  - `err`=1 one cycle after load.
  - Digit 1 shows 1001111, digit 0 shows 1111001, digits 2–3 blank.
  - A subsequent load of 0x0003 clears `err` next cycle.
- **Load 0x0042 mid-dwell of digit 1:**
  - `seg` switches to 0110011 on the next cycle.
  - The `an` dwell count is unbroken (digit 1 still totals 4 cycles).
- **Blank:** assert `blank` for 10 cycles → `an`/`seg`/`dp`=0 throughout. After release, the scan position is consistent with the uninterrupted count (10 cycles = 2.5 digits ahead).
- **Reset during digit 2 with `load` asserted:** next cycle all outputs are 0 and `digits_q`=0. The following cycle `an`=0001 and `seg`=1111110.
